// File: rtl/picosoc_mem_arb_pkg.sv
// rtl/picosoc_mem_arb_pkg.sv - shared state encoding, port indices and defaults for picosoc_mem_arb
package picosoc_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_e;

  localparam logic P_CPU  = 1'b0;
  localparam logic P_HOST = 1'b1;

  localparam int DEF_ADDR_W = 22;
  localparam int DEF_WORDS  = 256;

endpackage

// File: rtl/picosoc_rr_arb2.sv
// rtl/picosoc_rr_arb2.sv - two-input round-robin grant, pointer flips to the non-owner on advance
module picosoc_rr_arb2
  import picosoc_mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic advance_i,
  input  logic owner_i,
  output logic gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = ~owner_i;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= P_CPU;
    else     ptr_q <= ptr_d;
  end

  // The pointer only matters on a tie; a lone requester always wins.
  always_comb begin
    if (req0_i && req1_i) gnt_o = ptr_q;
    else if (req1_i)      gnt_o = P_HOST;
    else                  gnt_o = P_CPU;
  end

endmodule

// File: rtl/picosoc_mem_arb.sv
// rtl/picosoc_mem_arb.sv - two-port round-robin sequencer in front of the 1-cycle on-chip SRAM
// Optional grant/oor statistics outputs under PICOSOC_MEM_ARB_STATS_EN.
module picosoc_mem_arb
  import picosoc_mem_arb_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_wstrb,
  output logic              p0_ready,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_valid,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_wstrb,
  output logic              p1_ready,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef PICOSOC_MEM_ARB_STATS_EN
  output logic [31:0]       p0_grants,
  output logic [31:0]       p1_grants,
  output logic [15:0]       oor_count,
`endif
  input  logic [31:0]       mem_rdata
);

  // When the index port covers the whole SRAM, upper address bits simply alias.
  localparam bit FULL_MAP = (64'(WORDS) == (64'd1 << ADDR_W));

  function automatic logic is_oor(input logic [31:0] addr);
    logic [31:0] widx;
    widx = addr >> 2;
    if (FULL_MAP) return 1'b0;
    return widx >= 32'(WORDS);
  endfunction

  state_e             state_q;
  logic               owner_q;
  logic               oor_q;
  logic [3:0]         mem_wen_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               p0_ready_q, p1_ready_q;
  logic               p0_err_q, p1_err_q;

  logic               gnt;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_strb;
  logic               sel_oor;

  picosoc_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (p0_valid),
    .req1_i    (p1_valid),
    .advance_i (state_q == ACK),
    .owner_i   (owner_q),
    .gnt_o     (gnt)
  );

  always_comb begin
    sel_addr  = (gnt == P_HOST) ? p1_addr  : p0_addr;
    sel_wdata = (gnt == P_HOST) ? p1_wdata : p0_wdata;
    sel_strb  = (gnt == P_HOST) ? p1_wstrb : p0_wstrb;
    sel_oor   = is_oor(sel_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= P_CPU;
      oor_q       <= 1'b0;
      mem_wen_q   <= 4'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
    end else begin
      mem_wen_q  <= 4'b0;
      p0_ready_q <= 1'b0;
      p1_ready_q <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (p0_valid || p1_valid) begin
            owner_q     <= gnt;
            oor_q       <= sel_oor;
            mem_addr_q  <= sel_addr[ADDR_W+1:2];
            mem_wdata_q <= sel_wdata;
            mem_wen_q   <= sel_oor ? 4'b0 : sel_strb;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          p0_ready_q <= (owner_q == P_CPU);
          p1_ready_q <= (owner_q == P_HOST);
          p0_err_q   <= (owner_q == P_CPU)  && oor_q;
          p1_err_q   <= (owner_q == P_HOST) && oor_q;
          state_q    <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_ready  = p0_ready_q;
  assign p1_ready  = p1_ready_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  // SRAM data only arrives in ACK, so rdata is gated rather than registered.
  assign p0_rdata  = (p0_ready_q && !oor_q) ? mem_rdata : 32'd0;
  assign p1_rdata  = (p1_ready_q && !oor_q) ? mem_rdata : 32'd0;

`ifdef PICOSOC_MEM_ARB_STATS_EN
  logic [31:0] p0_grants_q, p1_grants_q;
  logic [15:0] oor_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_grants_q <= 32'd0;
      p1_grants_q <= 32'd0;
      oor_count_q <= 16'd0;
    end else if (state_q == ACK) begin
      if (owner_q == P_CPU) p0_grants_q <= p0_grants_q + 32'd1;
      else                  p1_grants_q <= p1_grants_q + 32'd1;
      if (oor_q && (oor_count_q != 16'hFFFF)) oor_count_q <= oor_count_q + 16'd1;
    end
  end

  assign p0_grants = p0_grants_q;
  assign p1_grants = p1_grants_q;
  assign oor_count = oor_count_q;
`endif

endmodule

// File: tb/tb_picosoc_mem_arb.sv
// tb/tb_picosoc_mem_arb.sv - directed self-checking bench for picosoc_mem_arb with a read-before-write SRAM model
module tb_picosoc_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_ready, p1_ready, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  mem_wen;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef PICOSOC_MEM_ARB_STATS_EN
  logic [31:0] p0_grants, p1_grants;
  logic [15:0] oor_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  picosoc_mem_arb dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef PICOSOC_MEM_ARB_STATS_EN
    .p0_grants(p0_grants), .p1_grants(p1_grants), .oor_count(oor_count),
`endif
    .mem_rdata(mem_rdata)
  );

  // Registered-read SRAM: the read returns the word as it was before this edge's write.
  always @(posedge clk) begin
    if (mem_addr < 22'd256) begin
      mem_rdata <= mem[mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else begin
      mem_rdata <= 32'hFFFF_FFFF;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic access(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int lat, output logic [3:0] wen_at1, output int wen_cycles,
                        output logic other_rdy);
    @(negedge clk);
    if (port == 0) begin
      p0_valid = 1'b1; p0_addr = addr; p0_wdata = wdata; p0_wstrb = strb;
    end else begin
      p1_valid = 1'b1; p1_addr = addr; p1_wdata = wdata; p1_wstrb = strb;
    end
    lat = 0; rdata = 32'd0; err = 1'b0; wen_at1 = 4'd0; wen_cycles = 0; other_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_wen != 4'd0) wen_cycles++;
      if (i == 1) wen_at1 = mem_wen;
      if ((port == 0) ? p1_ready : p0_ready) other_rdy = 1'b1;
      if ((port == 0) ? p0_ready : p1_ready) begin
        lat   = i;
        rdata = (port == 0) ? p0_rdata : p1_rdata;
        err   = (port == 0) ? p0_err : p1_err;
        break;
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (mem_wen !== 4'd0) $display("FAIL reset_mem_wen: got %h expected 0", mem_wen); else pass_cnt++;
    total_cnt++; if (mem_addr !== 22'd0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); else pass_cnt++;
    total_cnt++; if ({p0_ready, p1_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {p0_ready, p1_ready}); else pass_cnt++;
    total_cnt++; if ({p0_err, p1_err} !== 2'b00) $display("FAIL reset_err: got %b expected 00", {p0_err, p1_err}); else pass_cnt++;
    total_cnt++; if (p0_rdata !== 32'd0) $display("FAIL reset_p0_rdata: got %h expected 0", p0_rdata); else pass_cnt++;
    total_cnt++; if (p1_rdata !== 32'd0) $display("FAIL reset_p1_rdata: got %h expected 0", p1_rdata); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [31:0] rd; logic er; int lat; logic [3:0] w1; int wc; logic oth;
    access(0, 32'h14, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    total_cnt++; if (lat !== 2) $display("FAIL rd_latency: got %0d expected 2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hA5A5_0001) $display("FAIL rd_data: got %h expected a5a50001", rd); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL rd_err: got %b expected 0", er); else pass_cnt++;
    total_cnt++; if (wc !== 0) $display("FAIL rd_wen_cycles: got %0d expected 0", wc); else pass_cnt++;
    total_cnt++; if (oth !== 1'b0) $display("FAIL rd_other_ready: got %b expected 0", oth); else pass_cnt++;
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic er; int lat; logic [3:0] w1; int wc; logic oth;
    access(1, 32'h20, 32'h00CC_0000, 4'b0100, rd, er, lat, w1, wc, oth);
    total_cnt++; if (w1 !== 4'b0100) $display("FAIL bw_wen_issue: got %b expected 0100", w1); else pass_cnt++;
    total_cnt++; if (wc !== 1) $display("FAIL bw_wen_cycles: got %0d expected 1", wc); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL bw_latency: got %0d expected 2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'h1122_3344) $display("FAIL bw_prewrite_rdata: got %h expected 11223344", rd); else pass_cnt++;
    total_cnt++; if (oth !== 1'b0) $display("FAIL bw_other_ready: got %b expected 0", oth); else pass_cnt++;
    access(1, 32'h20, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    total_cnt++; if (rd !== 32'h11CC_3344) $display("FAIL bw_readback: got %h expected 11cc3344", rd); else pass_cnt++;
    total_cnt++; if (wc !== 0) $display("FAIL bw_read_wen: got %0d expected 0", wc); else pass_cnt++;
  endtask

  task automatic test_contention();
    int ev_port [4]; int ev_cyc [4]; logic [31:0] ev_data [4];
    int n; logic both;
    int exp_port [4]; int exp_cyc [4]; logic [31:0] exp_data [4];
    exp_port = '{0, 1, 0, 1};
    exp_cyc  = '{2, 5, 8, 11};
    exp_data = '{32'hA5A5_0001, 32'h9999_0009, 32'hA5A5_0001, 32'h9999_0009};
    n = 0; both = 1'b0;
    do_reset();
    p0_valid = 1'b1; p0_addr = 32'h14; p0_wdata = 32'd0; p0_wstrb = 4'd0;
    p1_valid = 1'b1; p1_addr = 32'h24; p1_wdata = 32'd0; p1_wstrb = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (p0_ready && p1_ready) both = 1'b1;
      if ((p0_ready || p1_ready) && n < 4) begin
        ev_port[n] = p1_ready ? 1 : 0;
        ev_cyc[n]  = i;
        ev_data[n] = p1_ready ? p1_rdata : p0_rdata;
        n++;
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    total_cnt++; if (n !== 4) $display("FAIL cont_grant_count: got %0d expected 4", n); else pass_cnt++;
    total_cnt++; if (both !== 1'b0) $display("FAIL cont_dual_ready: got %b expected 0", both); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        total_cnt++; if (ev_port[k] !== exp_port[k]) $display("FAIL cont_port[%0d]: got %0d expected %0d", k, ev_port[k], exp_port[k]); else pass_cnt++;
        total_cnt++; if (ev_cyc[k] !== exp_cyc[k]) $display("FAIL cont_cycle[%0d]: got %0d expected %0d", k, ev_cyc[k], exp_cyc[k]); else pass_cnt++;
        total_cnt++; if (ev_data[k] !== exp_data[k]) $display("FAIL cont_rdata[%0d]: got %h expected %h", k, ev_data[k], exp_data[k]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_oor();
    logic [31:0] rd; logic er; int lat; logic [3:0] w1; int wc; logic oth;
    access(0, 32'h400, 32'hDEAD_BEEF, 4'hF, rd, er, lat, w1, wc, oth);
    total_cnt++; if (wc !== 0) $display("FAIL oor_wen_cycles: got %0d expected 0", wc); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL oor_latency: got %0d expected 2", lat); else pass_cnt++;
    total_cnt++; if (er !== 1'b1) $display("FAIL oor_err: got %b expected 1", er); else pass_cnt++;
    total_cnt++; if (rd !== 32'd0) $display("FAIL oor_rdata: got %h expected 0", rd); else pass_cnt++;
    total_cnt++; if (mem[0] !== 32'h0BAD_0000) $display("FAIL oor_mem0: got %h expected 0bad0000", mem[0]); else pass_cnt++;
    access(0, 32'h3FC, 32'hCAFE_F00D, 4'hF, rd, er, lat, w1, wc, oth);
    total_cnt++; if (er !== 1'b0) $display("FAIL last_word_err: got %b expected 0", er); else pass_cnt++;
    total_cnt++; if (w1 !== 4'hF) $display("FAIL last_word_wen: got %h expected f", w1); else pass_cnt++;
    total_cnt++; if (mem[255] !== 32'hCAFE_F00D) $display("FAIL last_word_mem: got %h expected cafef00d", mem[255]); else pass_cnt++;
    access(1, 32'h8000_0010, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    total_cnt++; if (er !== 1'b1) $display("FAIL high_addr_err: got %b expected 1", er); else pass_cnt++;
    total_cnt++; if (rd !== 32'd0) $display("FAIL high_addr_rdata: got %h expected 0", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic [3:0] w1; int wc; logic oth;
    @(negedge clk);
    p0_valid = 1'b1; p0_addr = 32'h30; p0_wdata = 32'h5555_AAAA; p0_wstrb = 4'hF;
    @(negedge clk);
    total_cnt++; if (mem_wen !== 4'hF) $display("FAIL mid_issue_wen: got %h expected f", mem_wen); else pass_cnt++;
    rst = 1'b1; p0_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (mem_wen !== 4'd0) $display("FAIL mid_rst_wen: got %h expected 0", mem_wen); else pass_cnt++;
    total_cnt++; if ({p0_ready, p1_ready} !== 2'b00) $display("FAIL mid_rst_ready: got %b expected 00", {p0_ready, p1_ready}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (p0_ready !== 1'b0) $display("FAIL mid_rst_ready2: got %b expected 0", p0_ready); else pass_cnt++;
    rst = 1'b0;
    access(0, 32'h30, 32'h5555_AAAA, 4'hF, rd, er, lat, w1, wc, oth);
    total_cnt++; if (lat !== 2) $display("FAIL mid_reissue_latency: got %0d expected 2", lat); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL mid_reissue_err: got %b expected 0", er); else pass_cnt++;
    access(0, 32'h30, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    total_cnt++; if (rd !== 32'h5555_AAAA) $display("FAIL mid_readback: got %h expected 5555aaaa", rd); else pass_cnt++;
  endtask

`ifdef PICOSOC_MEM_ARB_STATS_EN
  task automatic test_stats();
    logic [31:0] rd; logic er; int lat; logic [3:0] w1; int wc; logic oth;
    do_reset();
    access(0, 32'h14, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    access(1, 32'h24, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    access(0, 32'h400, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    access(1, 32'h20, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    access(0, 32'h18, 32'd0, 4'd0, rd, er, lat, w1, wc, oth);
    @(negedge clk);
    total_cnt++; if (p0_grants !== 32'd3) $display("FAIL stats_p0: got %0d expected 3", p0_grants); else pass_cnt++;
    total_cnt++; if (p1_grants !== 32'd2) $display("FAIL stats_p1: got %0d expected 2", p1_grants); else pass_cnt++;
    total_cnt++; if (oor_count !== 16'd1) $display("FAIL stats_oor: got %0d expected 1", oor_count); else pass_cnt++;
    do_reset();
    total_cnt++; if ({p0_grants, p1_grants, oor_count} !== 80'd0) $display("FAIL stats_clear: got %h/%h/%h expected 0", p0_grants, p1_grants, oor_count); else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    p0_valid = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0; p0_wstrb = 4'd0;
    p1_valid = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0; p1_wstrb = 4'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h0BAD_0000;
    mem[5] = 32'hA5A5_0001;
    mem[8] = 32'h1122_3344;
    mem[9] = 32'h9999_0009;

    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_oor();
    test_reset_mid();
`ifdef PICOSOC_MEM_ARB_STATS_EN
    test_stats();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
